// File: rtl/hazard_pkg.sv
// Shared defaults and per-class pipeline timing (Tuse/Tnew) for the hazard scoreboard.
package hazard_pkg;

    localparam int TNEW_W_DEF   = 2;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    typedef enum logic [2:0] {
        CLS_CALC_R,
        CLS_CALC_I,
        CLS_LOAD,
        CLS_MFC0,
        CLS_BRANCH,
        CLS_JR,
        CLS_STORE
    } instr_class_e;

    typedef struct packed {
        logic [TNEW_W_DEF-1:0] tuse_rs;
        logic [TNEW_W_DEF-1:0] tuse_rt;
        logic [TNEW_W_DEF-1:0] tnew;
    } timing_t;

    // Tuse = cycles from ID until the operand is consumed; Tnew = cycles from issue until forwardable.
    localparam timing_t TIMING_CALC_R = '{tuse_rs: 2'd1, tuse_rt: 2'd1, tnew: 2'd1};
    localparam timing_t TIMING_CALC_I = '{tuse_rs: 2'd1, tuse_rt: 2'd3, tnew: 2'd1};
    localparam timing_t TIMING_LOAD   = '{tuse_rs: 2'd1, tuse_rt: 2'd3, tnew: 2'd2};
    localparam timing_t TIMING_MFC0   = '{tuse_rs: 2'd3, tuse_rt: 2'd3, tnew: 2'd2};
    localparam timing_t TIMING_BRANCH = '{tuse_rs: 2'd0, tuse_rt: 2'd0, tnew: 2'd0};
    localparam timing_t TIMING_JR     = '{tuse_rs: 2'd0, tuse_rt: 2'd3, tnew: 2'd0};
    localparam timing_t TIMING_STORE  = '{tuse_rs: 2'd1, tuse_rt: 2'd2, tnew: 2'd0};

    function automatic timing_t class_timing(input instr_class_e cls);
        timing_t t;
        case (cls)
            CLS_CALC_R: t = TIMING_CALC_R;
            CLS_CALC_I: t = TIMING_CALC_I;
            CLS_LOAD:   t = TIMING_LOAD;
            CLS_MFC0:   t = TIMING_MFC0;
            CLS_BRANCH: t = TIMING_BRANCH;
            CLS_JR:     t = TIMING_JR;
            CLS_STORE:  t = TIMING_STORE;
            default:    t = TIMING_CALC_R;
        endcase
        return t;
    endfunction

    function automatic int md_cnt_width(input int mult_cyc, input int div_cyc);
        return $clog2(((mult_cyc > div_cyc) ? mult_cyc : div_cyc) + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Signal bundle between the ID stage / mult-div control and hazard_scoreboard.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int TNEW_W = TNEW_W_DEF
);
    localparam int AW = $clog2(NREG);

    logic              id_valid;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [AW-1:0]     id_rs;
    logic [AW-1:0]     id_rt;
    logic [TNEW_W-1:0] id_tuse_rs;
    logic [TNEW_W-1:0] id_tuse_rt;
    logic              id_wr_en;
    logic [AW-1:0]     id_wr_addr;
    logic [TNEW_W-1:0] id_tnew;
    logic              id_is_md;
    logic              md_start;
    logic              md_is_div;
    logic              flush;
    logic              stall;
    logic              md_busy;

    modport master (
        output id_valid, id_use_rs, id_use_rt, id_rs, id_rt, id_tuse_rs, id_tuse_rt,
        output id_wr_en, id_wr_addr, id_tnew, id_is_md, md_start, md_is_div, flush,
        input  stall, md_busy
    );

    modport slave (
        input  id_valid, id_use_rs, id_use_rt, id_rs, id_rt, id_tuse_rs, id_tuse_rt,
        input  id_wr_en, id_wr_addr, id_tnew, id_is_md, md_start, md_is_div, flush,
        output stall, md_busy
    );

endinterface

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Mult/div busy countdown; only built when HAZARD_SCOREBOARD_MD_EN is defined.
`ifdef HAZARD_SCOREBOARD_MD_EN
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o
);
    localparam int CW = md_cnt_width(MULT_CYC, DIV_CYC);

    logic [CW-1:0] md_cnt_q;
    logic [CW-1:0] md_cnt_d;

    // A start while already counting is a protocol error and is dropped.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end else if (start_i) begin
            md_cnt_d = is_div_i ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign busy_o = (md_cnt_q != '0);

endmodule
`endif

// File: rtl/hazard_scoreboard.sv
// Per-register Tnew/Tuse stall scoreboard; optional mult/div busy tracking under HAZARD_SCOREBOARD_MD_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int TNEW_W   = TNEW_W_DEF,
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave sb
);
    localparam int AW = $clog2(NREG);

    logic [TNEW_W-1:0] pend_q [NREG];
    logic [TNEW_W-1:0] pend_d [NREG];

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;
    logic issue;
    logic md_busy;

    // Stall reads pre-edge pend values, so a same-cycle write never hides a hazard.
    always_comb begin
        stall_rs = sb.id_use_rs & (sb.id_rs != '0) & (pend_q[sb.id_rs] > sb.id_tuse_rs);
        stall_rt = sb.id_use_rt & (sb.id_rt != '0) & (pend_q[sb.id_rt] > sb.id_tuse_rt);
        stall    = sb.id_valid & (stall_rs | stall_rt | stall_md);
        issue    = sb.id_valid & ~stall;
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = (pend_q[r] != '0) ? pend_q[r] - 1'b1 : '0;
            if (issue && sb.id_wr_en && (sb.id_wr_addr == AW'(r))) begin
                pend_d[r] = sb.id_tnew;
            end
            if (sb.flush || (r == 0)) begin
                pend_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end

`ifdef HAZARD_SCOREBOARD_MD_EN
    md_busy_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .start_i  (sb.md_start),
        .is_div_i (sb.md_is_div),
        .busy_o   (md_busy)
    );

    assign stall_md = sb.id_is_md & (md_busy | sb.md_start);
`else
    logic unused_md;

    assign md_busy   = 1'b0;
    assign stall_md  = 1'b0;
    assign unused_md = ^{sb.md_start, sb.md_is_div, sb.id_is_md, 1'(MULT_CYC), 1'(DIV_CYC)};
`endif

    assign sb.stall   = stall;
    assign sb.md_busy = md_busy;

endmodule
